// File: rtl/uart_cmd_rx.sv
//------------------------------------------------------------------------------
// uart_cmd_rx
//
// Serial command receiver for the host link. Deserializes 8N1 bytes from the
// host (8E1 when UART_CMD_RX_PARITY_EN is defined) and decodes the
// nibble-packed command protocol into one-cycle command strobes.
//
// Each received byte is split into an opcode (low nibble) and a data
// nibble n (high nibble):
//   0x0      SET_INDEX  select line n (if n < NUM_LINES), strobe opcode 0
//   0x1      PUSH       shift n into the 16-bit value accumulator
//   0x2-0x7  command    strobe with value {acc[11:0], n}, then clear acc
//   0x8-0xF  reserved   cmd_error, clear acc
//
// Optional feature macro: UART_CMD_RX_PARITY_EN
//   Adds an even-parity bit between the data bits and the stop bit, and the
//   parity_error output. Bytes that fail parity are never decoded.
//
// Ports:
//   clki          in   system clock, all logic on the rising edge
//   reset         in   synchronous active-high reset
//   rx            in   serial input, idle high, asynchronous to clki
//   byte_valid    out  one-cycle pulse per correctly framed byte
//   byte_data     out  [7:0]  last received byte, held
//   cmd_valid     out  one-cycle command strobe
//   cmd_opcode    out  [3:0]  opcode of the last strobed command, held
//   cmd_index     out  [3:0]  current line index register
//   cmd_value     out  [15:0] value of the last strobed command, held
//   frame_error   out  one-cycle pulse on a bad stop bit
//   cmd_error     out  one-cycle pulse on an illegal command
//   busy          out  high while a frame is in progress
//   parity_error  out  one-cycle pulse on a parity failure (parity build only)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_cmd_rx #(
    parameter int CLK_FREQUENCY = 500000000,
    parameter int BAUD_RATE     = 57600,
    parameter int NUM_LINES     = 4
) (
    input  logic        clki,
    input  logic        reset,
    input  logic        rx,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        cmd_valid,
    output logic [3:0]  cmd_opcode,
    output logic [3:0]  cmd_index,
    output logic [15:0] cmd_value,
    output logic        frame_error,
    output logic        cmd_error,
    output logic        busy
`ifdef UART_CMD_RX_PARITY_EN
    ,
    output logic        parity_error
`endif
);

    localparam int DIV   = CLK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [4:0]       LINES_W   = 5'(NUM_LINES);

    // Oversampling below 8 cannot place the sample point reliably mid-bit.
    if (DIV < 8) begin : gDivCheck
        $error("uart_cmd_rx: CLK_FREQUENCY/BAUD_RATE must be >= 8");
    end
    if (NUM_LINES > 16 || NUM_LINES < 1) begin : gLinesCheck
        $error("uart_cmd_rx: NUM_LINES must be in 1..16");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
`ifdef UART_CMD_RX_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    state_t            state_q;
    logic              rxMeta_q;
    logic              rxSync_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bitCnt_q;
    logic [7:0]        shift_q;
    logic [15:0]       acc_q;
    logic              byteValid_q;
    logic [7:0]        byteData_q;
    logic              cmdValid_q;
    logic [3:0]        cmdOpcode_q;
    logic [3:0]        cmdIndex_q;
    logic [15:0]       cmdValue_q;
    logic              frameError_q;
    logic              cmdError_q;

    logic [3:0]        rxOpcode;
    logic [3:0]        rxNibble;
    logic [15:0]       pushedValue;
    logic              decodeOk;

    assign rxOpcode    = shift_q[3:0];
    assign rxNibble    = shift_q[7:4];
    assign pushedValue = {acc_q[11:0], rxNibble};

`ifdef UART_CMD_RX_PARITY_EN
    logic parityOk_q;
    logic parityError_q;
    assign decodeOk     = parityOk_q;
    assign parity_error = parityError_q;
`else
    assign decodeOk = 1'b1;
`endif

    // Two-flop synchronizer for the asynchronous serial line; idles high so a
    // reset never looks like a start bit.
    always_ff @(posedge clki) begin
        if (reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // Receive FSM, baud timing and command decoder. The decoder runs on the
    // same edge that accepts the stop bit so byte_valid and cmd_valid/cmd_error
    // appear together. Returning to IDLE at mid-stop-bit leaves half a bit of
    // margin to catch a start bit that follows with no idle gap.
    always_ff @(posedge clki) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bitCnt_q     <= '0;
            shift_q      <= '0;
            acc_q        <= '0;
            byteValid_q  <= 1'b0;
            byteData_q   <= '0;
            cmdValid_q   <= 1'b0;
            cmdOpcode_q  <= '0;
            cmdIndex_q   <= '0;
            cmdValue_q   <= '0;
            frameError_q <= 1'b0;
            cmdError_q   <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            parityOk_q    <= 1'b0;
            parityError_q <= 1'b0;
`endif
        end else begin
            byteValid_q  <= 1'b0;
            cmdValid_q   <= 1'b0;
            frameError_q <= 1'b0;
            cmdError_q   <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            parityError_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rxSync_q) begin
                        cnt_q   <= HALF_LOAD;
                        state_q <= START;
                    end
                end

                START: begin
                    if (cnt_q == '0) begin
                        if (rxSync_q) begin
                            // Low pulse shorter than half a bit: a glitch.
                            state_q <= IDLE;
                        end else begin
                            cnt_q    <= FULL_LOAD;
                            bitCnt_q <= '0;
                            state_q  <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rxSync_q, shift_q[7:1]};
                        cnt_q   <= FULL_LOAD;
                        if (bitCnt_q == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bitCnt_q <= bitCnt_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

`ifdef UART_CMD_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == '0) begin
                        // Even parity: data bits plus parity bit XOR to zero.
                        parityOk_q <= ~(^shift_q ^ rxSync_q);
                        cnt_q      <= FULL_LOAD;
                        state_q    <= STOP;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
`endif

                STOP: begin
                    if (cnt_q == '0) begin
`ifdef UART_CMD_RX_PARITY_EN
                        parityError_q <= ~parityOk_q;
`endif
                        if (!rxSync_q) begin
                            frameError_q <= 1'b1;
                            state_q      <= WAIT_IDLE;
                        end else begin
                            state_q <= IDLE;
                            if (decodeOk) begin
                                byteValid_q <= 1'b1;
                                byteData_q  <= shift_q;
                                if (rxOpcode == 4'h0) begin
                                    if ({1'b0, rxNibble} < LINES_W) begin
                                        cmdIndex_q  <= rxNibble;
                                        cmdValid_q  <= 1'b1;
                                        cmdOpcode_q <= 4'h0;
                                        cmdValue_q  <= {12'h000, rxNibble};
                                    end else begin
                                        cmdError_q <= 1'b1;
                                    end
                                end else if (rxOpcode == 4'h1) begin
                                    acc_q <= pushedValue;
                                end else if (!rxOpcode[3]) begin
                                    cmdValid_q  <= 1'b1;
                                    cmdOpcode_q <= rxOpcode;
                                    cmdValue_q  <= pushedValue;
                                    acc_q       <= '0;
                                end else begin
                                    cmdError_q <= 1'b1;
                                    acc_q      <= '0;
                                end
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                WAIT_IDLE: begin
                    // Hold off during a break so it yields a single frame_error.
                    if (rxSync_q) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_valid  = byteValid_q;
    assign byte_data   = byteData_q;
    assign cmd_valid   = cmdValid_q;
    assign cmd_opcode  = cmdOpcode_q;
    assign cmd_index   = cmdIndex_q;
    assign cmd_value   = cmdValue_q;
    assign frame_error = frameError_q;
    assign cmd_error   = cmdError_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
//------------------------------------------------------------------------------
// tb_uart_cmd_rx
//
// Self-checking bench for uart_cmd_rx at DIV = 20. A negedge monitor records
// every output pulse into queues; a protocol-level model turns each sent byte
// into the expected bytes, command strobes and error counts.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_cmd_rx;

    localparam int CLK_FREQUENCY = 1152000;
    localparam int BAUD_RATE     = 57600;
    localparam int NUM_LINES     = 4;
    localparam int DIV           = CLK_FREQUENCY / BAUD_RATE;

    logic        clki = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        cmd_valid;
    logic [3:0]  cmd_opcode;
    logic [3:0]  cmd_index;
    logic [15:0] cmd_value;
    logic        frame_error;
    logic        cmd_error;
    logic        busy;
`ifdef UART_CMD_RX_PARITY_EN
    logic        parity_error;
`endif

    int checks = 0;
    int errors = 0;

    // Observed activity
    logic [7:0]  obsBytes[$];
    logic [23:0] obsCmds[$];
    int          obsFrameErr;
    int          obsCmdErr;
    int          obsParErr;
    bit          sawBusy;

    // Reference model state and expectations
    int          mAcc;
    int          mIdx;
    logic [7:0]  expBytes[$];
    logic [23:0] expCmds[$];
    int          expCmdErr;

    uart_cmd_rx #(
        .CLK_FREQUENCY(CLK_FREQUENCY),
        .BAUD_RATE    (BAUD_RATE),
        .NUM_LINES    (NUM_LINES)
    ) dut (
        .clki        (clki),
        .reset       (reset),
        .rx          (rx),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .cmd_valid   (cmd_valid),
        .cmd_opcode  (cmd_opcode),
        .cmd_index   (cmd_index),
        .cmd_value   (cmd_value),
        .frame_error (frame_error),
        .cmd_error   (cmd_error),
        .busy        (busy)
`ifdef UART_CMD_RX_PARITY_EN
        ,
        .parity_error(parity_error)
`endif
    );

    always #5 clki = ~clki;

    // Record every pulse half a cycle after the edge that produced it.
    always @(negedge clki) begin
        if (!reset) begin
            if (byte_valid) obsBytes.push_back(byte_data);
            if (cmd_valid) obsCmds.push_back({cmd_opcode, cmd_value, cmd_index});
            if (frame_error) obsFrameErr++;
            if (cmd_error) obsCmdErr++;
`ifdef UART_CMD_RX_PARITY_EN
            if (parity_error) obsParErr++;
`endif
            if (busy) sawBusy = 1'b1;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors %0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearObs();
        obsBytes.delete();
        obsCmds.delete();
        expBytes.delete();
        expCmds.delete();
        obsFrameErr = 0;
        obsCmdErr   = 0;
        obsParErr   = 0;
        expCmdErr   = 0;
        sawBusy     = 1'b0;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clki);
        #1;
        reset = 1'b0;
        mAcc  = 0;
        mIdx  = 0;
        clearObs();
    endtask

    // Protocol model: what one correctly received byte should cause.
    task automatic modelByte(input logic [7:0] b);
        int op;
        int n;
        int val;
        op  = int'(b) % 16;
        n   = int'(b) / 16;
        val = (mAcc * 16 + n) % 65536;
        expBytes.push_back(b);
        if (op == 0) begin
            if (n < NUM_LINES) begin
                mIdx = n;
                expCmds.push_back({4'(op), 16'(n), 4'(mIdx)});
            end else begin
                expCmdErr++;
            end
        end else if (op == 1) begin
            mAcc = val;
        end else if (op < 8) begin
            expCmds.push_back({4'(op), 16'(val), 4'(mIdx)});
            mAcc = 0;
        end else begin
            expCmdErr++;
            mAcc = 0;
        end
    endtask

    task automatic driveBit(input logic v);
        rx = v;
        repeat (DIV) @(posedge clki);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit goodStop, input bit goodParity);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(b[i]);
`ifdef UART_CMD_RX_PARITY_EN
        driveBit((^b) ^ !goodParity);
`endif
        driveBit(goodStop);
        if (goodStop && goodParity) modelByte(b);
    endtask

    task automatic settle();
        int n;
        n = 0;
        rx = 1'b1;
        while (busy && n < 1000) begin
            @(posedge clki);
            #1;
            n++;
        end
        repeat (5) @(posedge clki);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL settle: busy still %b after bound, required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clki);
        #1;
        checks++;
        if ({byte_valid, byte_data, cmd_valid, cmd_opcode, cmd_index, cmd_value, frame_error, cmd_error} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {byte_valid, byte_data, cmd_valid, cmd_opcode, cmd_index, cmd_value, frame_error, cmd_error});
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b required 0", busy);
        end
        resetDut();
    endtask

    task automatic test_push_strobe();
        resetDut();
        applyStimulus(8'h12, 1'b1, 1'b1);
        applyStimulus(8'h32, 1'b1, 1'b1);
        applyStimulus(8'h53, 1'b1, 1'b1);
        applyStimulus(8'h02, 1'b1, 1'b1);
        settle();
        checks++;
        if (obsBytes.size() != expBytes.size()) begin
            errors++;
            $display("[TB] FAIL push_byte_count: got %0d required %0d", obsBytes.size(), expBytes.size());
        end else begin
            for (int i = 0; i < expBytes.size(); i++) begin
                checks++;
                if (obsBytes[i] !== expBytes[i]) begin
                    errors++;
                    $display("[TB] FAIL push_byte[%0d]: got %h required %h", i, obsBytes[i], expBytes[i]);
                end
            end
        end
        checks++;
        if (obsCmds.size() != expCmds.size()) begin
            errors++;
            $display("[TB] FAIL push_cmd_count: got %0d required %0d", obsCmds.size(), expCmds.size());
        end else begin
            for (int i = 0; i < expCmds.size(); i++) begin
                checks++;
                if (obsCmds[i] !== expCmds[i]) begin
                    errors++;
                    $display("[TB] FAIL push_cmd[%0d]: got %h required %h", i, obsCmds[i], expCmds[i]);
                end
            end
        end
        checks++;
        if ({cmd_opcode, cmd_value} !== 20'h20000) begin
            errors++;
            $display("[TB] FAIL push_held: got %h required 20000", {cmd_opcode, cmd_value});
        end
    endtask

    task automatic test_set_index();
        resetDut();
        applyStimulus(8'h20, 1'b1, 1'b1);
        applyStimulus(8'h50, 1'b1, 1'b1);
        settle();
        checks++;
        if (obsCmds.size() != expCmds.size()) begin
            errors++;
            $display("[TB] FAIL index_cmd_count: got %0d required %0d", obsCmds.size(), expCmds.size());
        end else begin
            for (int i = 0; i < expCmds.size(); i++) begin
                checks++;
                if (obsCmds[i] !== expCmds[i]) begin
                    errors++;
                    $display("[TB] FAIL index_cmd[%0d]: got %h required %h", i, obsCmds[i], expCmds[i]);
                end
            end
        end
        checks++;
        if (obsCmdErr != expCmdErr) begin
            errors++;
            $display("[TB] FAIL index_cmd_error: got %0d required %0d", obsCmdErr, expCmdErr);
        end
        checks++;
        if (cmd_index !== 4'(mIdx)) begin
            errors++;
            $display("[TB] FAIL index_reg: got %0d required %0d", cmd_index, mIdx);
        end
        checks++;
        if ({cmd_opcode, cmd_value} !== 20'h00002) begin
            errors++;
            $display("[TB] FAIL index_held: got %h required 00002", {cmd_opcode, cmd_value});
        end
    endtask

    task automatic test_glitch();
        resetDut();
        rx = 1'b0;
        repeat (6) @(posedge clki);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clki);
        #1;
        checks++;
        if (sawBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL glitch_busy_rise: got %b required 1", sawBusy);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_busy_fall: got %b required 0", busy);
        end
        checks++;
        if (obsBytes.size() + obsFrameErr + obsCmdErr != 0) begin
            errors++;
            $display("[TB] FAIL glitch_pulses: got bytes %0d frame %0d cmd %0d required 0",
                     obsBytes.size(), obsFrameErr, obsCmdErr);
        end
    endtask

    task automatic test_break();
        resetDut();
        applyStimulus(8'h3C, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (400) @(posedge clki);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL break_busy_held: got %b required 1", busy);
        end
        rx = 1'b1;
        repeat (5) @(posedge clki);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL break_busy_release: got %b required 0", busy);
        end
        checks++;
        if (obsFrameErr != 1 || obsBytes.size() != 0) begin
            errors++;
            $display("[TB] FAIL break_pulses: got frame %0d bytes %0d required frame 1 bytes 0",
                     obsFrameErr, obsBytes.size());
        end
        applyStimulus(8'h04, 1'b1, 1'b1);
        settle();
        checks++;
        if (obsCmds.size() != 1 || expCmds.size() != 1) begin
            errors++;
            $display("[TB] FAIL break_next_count: got %0d required 1", obsCmds.size());
        end else if (obsCmds[0] !== expCmds[0]) begin
            errors++;
            $display("[TB] FAIL break_next_cmd: got %h required %h", obsCmds[0], expCmds[0]);
        end
    endtask

    task automatic test_reset_abort();
        resetDut();
        applyStimulus(8'h11, 1'b1, 1'b1);
        applyStimulus(8'h21, 1'b1, 1'b1);
        // Start of 0x15 then half of its first data bit (a one).
        driveBit(1'b0);
        rx = 1'b1;
        repeat (10) @(posedge clki);
        #1;
        reset = 1'b1;
        @(posedge clki);
        #1;
        reset = 1'b0;
        mAcc  = 0;
        mIdx  = 0;
        clearObs();
        repeat (300) @(posedge clki);
        #1;
        checks++;
        if (obsBytes.size() + obsFrameErr + obsCmdErr + obsCmds.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_quiet: got bytes %0d frame %0d cmderr %0d cmds %0d busy %b required all 0",
                     obsBytes.size(), obsFrameErr, obsCmdErr, obsCmds.size(), busy);
        end
        applyStimulus(8'h72, 1'b1, 1'b1);
        settle();
        checks++;
        if (obsCmds.size() != 1 || expCmds.size() != 1) begin
            errors++;
            $display("[TB] FAIL abort_next_count: got %0d required 1", obsCmds.size());
        end else if (obsCmds[0] !== expCmds[0]) begin
            errors++;
            $display("[TB] FAIL abort_next_cmd: got %h required %h", obsCmds[0], expCmds[0]);
        end
    endtask

    task automatic test_push_overflow();
        logic [7:0] seqA[6];
        logic [7:0] seqB[6];
        seqA = '{8'h11, 8'h21, 8'h31, 8'h41, 8'h51, 8'h63};
        seqB = '{8'h19, 8'h29, 8'h39, 8'h49, 8'h59, 8'h63};
        resetDut();
        foreach (seqA[i]) applyStimulus(seqA[i], 1'b1, 1'b1);
        foreach (seqB[i]) applyStimulus(seqB[i], 1'b1, 1'b1);
        settle();
        checks++;
        if (obsCmds.size() != expCmds.size()) begin
            errors++;
            $display("[TB] FAIL overflow_cmd_count: got %0d required %0d", obsCmds.size(), expCmds.size());
        end else begin
            for (int i = 0; i < expCmds.size(); i++) begin
                checks++;
                if (obsCmds[i] !== expCmds[i]) begin
                    errors++;
                    $display("[TB] FAIL overflow_cmd[%0d]: got %h required %h", i, obsCmds[i], expCmds[i]);
                end
            end
        end
        checks++;
        if (obsCmdErr != expCmdErr) begin
            errors++;
            $display("[TB] FAIL overflow_cmd_error: got %0d required %0d", obsCmdErr, expCmdErr);
        end
    endtask

`ifdef UART_CMD_RX_PARITY_EN
    task automatic test_parity();
        resetDut();
        applyStimulus(8'h63, 1'b1, 1'b0);
        settle();
        checks++;
        if (obsParErr != 1 || obsFrameErr != 0) begin
            errors++;
            $display("[TB] FAIL parity_pulse: got parity %0d frame %0d required 1 and 0", obsParErr, obsFrameErr);
        end
        checks++;
        if (obsCmds.size() != 0 || obsBytes.size() != 0) begin
            errors++;
            $display("[TB] FAIL parity_discard: got cmds %0d bytes %0d required 0", obsCmds.size(), obsBytes.size());
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] b;
        resetDut();
        for (int k = 0; k < 40; k++) begin
            b[3:0] = ($urandom_range(0, 1) == 1) ? 4'h1 : 4'($urandom_range(0, 15));
            b[7:4] = 4'($urandom_range(0, 15));
            applyStimulus(b, 1'b1, 1'b1);
            rx = 1'b1;
            repeat ($urandom_range(0, 30)) @(posedge clki);
            #1;
        end
        settle();
        checks++;
        if (obsBytes.size() != expBytes.size()) begin
            errors++;
            $display("[TB] FAIL random_byte_count: got %0d required %0d", obsBytes.size(), expBytes.size());
        end else begin
            for (int i = 0; i < expBytes.size(); i++) begin
                checks++;
                if (obsBytes[i] !== expBytes[i]) begin
                    errors++;
                    $display("[TB] FAIL random_byte[%0d]: got %h required %h", i, obsBytes[i], expBytes[i]);
                end
            end
        end
        checks++;
        if (obsCmds.size() != expCmds.size()) begin
            errors++;
            $display("[TB] FAIL random_cmd_count: got %0d required %0d", obsCmds.size(), expCmds.size());
        end else begin
            for (int i = 0; i < expCmds.size(); i++) begin
                checks++;
                if (obsCmds[i] !== expCmds[i]) begin
                    errors++;
                    $display("[TB] FAIL random_cmd[%0d]: got %h required %h", i, obsCmds[i], expCmds[i]);
                end
            end
        end
        checks++;
        if (obsCmdErr != expCmdErr || cmd_index !== 4'(mIdx)) begin
            errors++;
            $display("[TB] FAIL random_err_index: got err %0d idx %0d required err %0d idx %0d",
                     obsCmdErr, cmd_index, expCmdErr, mIdx);
        end
    endtask

    initial begin
        clearObs();
        test_reset();
        test_push_strobe();
        test_set_index();
        test_glitch();
        test_break();
        test_reset_abort();
        test_push_overflow();
`ifdef UART_CMD_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
